// File: rtl/ofm_writer_if.sv
// Bus bundle for ofm_writer: PE result handshake on one side, OFM memory write port on the other.
interface ofm_writer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7
) ();
    logic [DATA_W-1:0] data_in;
    logic              data_vld;
    logic              wr_ack;
    logic              mem_grant;
    logic              ofm_we;
    logic [ADDR_W-1:0] ofm_adr;
    logic [DATA_W-1:0] ofm_data;

    modport master (
        output data_in, data_vld, mem_grant,
        input  wr_ack, ofm_we, ofm_adr, ofm_data
    );

    modport slave (
        input  data_in, data_vld, mem_grant,
        output wr_ack, ofm_we, ofm_adr, ofm_data
    );
endinterface

// File: rtl/ofm_writer.sv
// OFM writer for one PE: queues packed PE results in a small FIFO and writes them to
// consecutive OFM addresses, pulsing done once the programmed number of words is written.
module ofm_writer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_adr_i,
    input  logic [ADDR_W-1:0] word_cnt_i,
    ofm_writer_if.slave       bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
    logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic empty_c;
    logic full_c;
    logic pop_c;
    logic push_c;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_c   = (state_q == ST_RUN) && !empty_c && bus.mem_grant;
    assign push_c  = (state_q == ST_RUN) && bus.data_vld && (in_cnt_q < count_q) &&
                     (!full_c || pop_c);

    assign bus.ofm_we   = pop_c;
    assign bus.ofm_adr  = pop_c ? ADDR_W'(base_q + out_cnt_q) : '0;
    assign bus.ofm_data = pop_c ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;
    assign bus.wr_ack   = ack_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // FIFO storage needs no reset: it is only read while non-empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.data_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d    = base_adr_i;
                    count_d   = word_cnt_i;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = (word_cnt_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (push_c) begin
                    in_cnt_d = in_cnt_q + ADDR_W'(1);
                    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
                end
                if (pop_c) begin
                    out_cnt_d = out_cnt_q + ADDR_W'(1);
                    rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
                end
                if (bus.data_vld && !push_c) begin
                    ovf_d = 1'b1;
                end
                if (pop_c && ((out_cnt_q + ADDR_W'(1)) == count_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d  = push_c;
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_ofm_writer.sv
// Self-checking bench for ofm_writer: directed vector table, corner-case sequences and
// random traffic compared cycle by cycle against a queue-based reference model.
module tb_ofm_writer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_adr = '0;
    logic [ADDR_W-1:0] word_cnt = '0;
    logic              busy;
    logic              done;
    logic              overflow;

    ofm_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ofm_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .base_adr_i (base_adr),
        .word_cnt_i (word_cnt),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: phase 0=idle 1=run 2=done, queue holds words waiting for the memory.
    int          m_phase = 0;
    logic [31:0] m_q[$];
    int          m_pushed = 0, m_written = 0, m_base = 0, m_cnt = 0;
    bit          m_ovf = 0, m_ack = 0;
    int          n_writes = 0;

    task automatic step(input bit r, input bit s, input int b, input int c,
                        input bit v, input logic [31:0] d, input bit g);
        bit          e_we, do_push;
        logic [31:0] e_adr, e_data;
        @(negedge clk);
        rst = r; start = s; base_adr = ADDR_W'(b); word_cnt = ADDR_W'(c);
        bus.data_vld = v; bus.data_in = d; bus.mem_grant = g;
        #1;
        e_we   = (m_phase == 1) && (m_q.size() > 0) && g;
        e_adr  = e_we ? 32'((m_base + m_written) % 128) : 32'd0;
        e_data = e_we ? m_q[0] : 32'd0;
        cmp("ofm_we",   32'(bus.ofm_we),  32'(e_we));
        cmp("ofm_adr",  32'(bus.ofm_adr), e_adr);
        cmp("ofm_data", bus.ofm_data,     e_data);
        cmp("wr_ack",   32'(bus.wr_ack),  32'(m_ack));
        cmp("busy",     32'(busy),        32'(m_phase == 1));
        cmp("done",     32'(done),        32'(m_phase == 2));
        cmp("overflow", 32'(overflow),    32'(m_ovf));
        if (bus.ofm_we) n_writes++;
        if (r) begin
            m_phase = 0; m_q.delete(); m_pushed = 0; m_written = 0;
            m_base = 0; m_cnt = 0; m_ovf = 0; m_ack = 0;
        end else if (m_phase == 0) begin
            m_ack = 0;
            if (s) begin
                m_base = b % 128; m_cnt = c % 128; m_pushed = 0; m_written = 0; m_ovf = 0;
                m_phase = (m_cnt == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            do_push = v && (m_pushed < m_cnt) && ((m_q.size() < DEPTH) || e_we);
            if (v && !do_push) m_ovf = 1;
            if (e_we) begin
                void'(m_q.pop_front());
                m_written++;
            end
            if (do_push) begin
                m_q.push_back(d);
                m_pushed++;
            end
            m_ack = do_push;
            if (e_we && m_written == m_cnt) m_phase = 2;
        end else begin
            m_ack = 0;
            m_phase = 0;
        end
    endtask

    typedef struct {
        bit          rst, start;
        int          base, cnt;
        bit          vld;
        logic [31:0] data;
        bit          grant;
        bit          we;
        int          adr;
        logic [31:0] wdata;
        bit          ack, busy, done, ovf;
    } vec_t;

    function automatic vec_t mk(int r, int s, int b, int c, int v, logic [31:0] d, int g,
                                int we, int adr, logic [31:0] wd, int ack, int bsy, int dn, int ov);
        vec_t t;
        t.rst = 1'(r); t.start = 1'(s); t.base = b; t.cnt = c; t.vld = 1'(v); t.data = d;
        t.grant = 1'(g); t.we = 1'(we); t.adr = adr; t.wdata = wd;
        t.ack = 1'(ack); t.busy = 1'(bsy); t.done = 1'(dn); t.ovf = 1'(ov);
        return t;
    endfunction

    vec_t vt[$];

    initial begin
        bus.data_in = '0; bus.data_vld = 1'b0; bus.mem_grant = 1'b0;

        // base 10, three words spaced two cycles apart, then data_vld in idle
        vt.push_back(mk(1,0,0,0,  0,0,0,            0,0,0,0,0,0,0));
        vt.push_back(mk(0,1,10,3, 0,0,1,            0,0,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,  1,32'h11110001,1, 0,0,0,0,1,0,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            1,10,32'h11110001,1,1,0,0));
        vt.push_back(mk(0,0,0,0,  1,32'h11110002,1, 0,0,0,0,1,0,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            1,11,32'h11110002,1,1,0,0));
        vt.push_back(mk(0,0,0,0,  1,32'h11110003,1, 0,0,0,0,1,0,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            1,12,32'h11110003,1,1,0,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            0,0,0,0,0,1,0));
        vt.push_back(mk(0,0,0,0,  1,32'h0000dead,1, 0,0,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            0,0,0,0,0,0,0));
        // zero-length run
        vt.push_back(mk(0,1,5,0,  0,0,1,            0,0,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            0,0,0,0,0,1,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            0,0,0,0,0,0,0));
        // address wrap from 126
        vt.push_back(mk(0,1,126,3,0,0,1,            0,0,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,  1,32'haaaa0001,1, 0,0,0,0,1,0,0));
        vt.push_back(mk(0,0,0,0,  1,32'haaaa0002,1, 1,126,32'haaaa0001,1,1,0,0));
        vt.push_back(mk(0,0,0,0,  1,32'haaaa0003,1, 1,127,32'haaaa0002,1,1,0,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            1,0,32'haaaa0003,1,1,0,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            0,0,0,0,0,1,0));
        vt.push_back(mk(0,0,0,0,  0,0,1,            0,0,0,0,0,0,0));

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].rst, vt[i].start, vt[i].base, vt[i].cnt, vt[i].vld, vt[i].data, vt[i].grant);
            cmp($sformatf("vec%0d.we", i),   32'(bus.ofm_we),  32'(vt[i].we));
            cmp($sformatf("vec%0d.adr", i),  32'(bus.ofm_adr), 32'(vt[i].adr));
            cmp($sformatf("vec%0d.data", i), bus.ofm_data,     vt[i].wdata);
            cmp($sformatf("vec%0d.ack", i),  32'(bus.wr_ack),  32'(vt[i].ack));
            cmp($sformatf("vec%0d.busy", i), 32'(busy),        32'(vt[i].busy));
            cmp($sformatf("vec%0d.done", i), 32'(done),        32'(vt[i].done));
            cmp($sformatf("vec%0d.ovf", i),  32'(overflow),    32'(vt[i].ovf));
        end

        // Fill the FIFO with grant low, then drain four words in four cycles
        step(0,1,20,4, 0,0,0);
        for (int i = 0; i < 4; i++) step(0,0,0,0, 1,32'hb0000000 + 32'(i),0);
        n_writes = 0;
        step(0,0,0,0, 0,0,0);
        cmp("full_no_write", 32'(n_writes), 32'd0);
        for (int i = 0; i < 4; i++) step(0,0,0,0, 0,0,1);
        cmp("drain_writes", 32'(n_writes), 32'd4);
        step(0,0,0,0, 0,0,1);
        cmp("drain_done", 32'(done), 32'd1);
        step(0,0,0,0, 0,0,1);

        // Word offered into a full FIFO is dropped and overflow stays until the next start
        step(0,1,40,8, 0,0,0);
        for (int i = 0; i < 4; i++) step(0,0,0,0, 1,32'hc0000000 + 32'(i),0);
        step(0,0,0,0, 1,32'hc00000ff,0);
        step(0,0,0,0, 0,0,0);
        cmp("drop_no_ack", 32'(bus.wr_ack), 32'd0);
        cmp("drop_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) step(0,0,0,0, 0,0,1);
        for (int i = 0; i < 4; i++) begin
            step(0,0,0,0, 1,32'hc0000010 + 32'(i),1);
            step(0,0,0,0, 0,0,1);
        end
        for (int i = 0; i < 20 && m_phase != 0; i++) step(0,0,0,0, 0,0,1);
        cmp("run_end_timeout", 32'(m_phase), 32'd0);
        cmp("ovf_sticky", 32'(overflow), 32'd1);
        step(0,1,0,0, 0,0,1);
        step(0,0,0,0, 0,0,1);
        cmp("ovf_cleared", 32'(overflow), 32'd0);
        step(0,0,0,0, 0,0,1);

        // Reset with two words queued: nothing else is written
        step(0,1,60,4, 0,0,0);
        step(0,0,0,0, 1,32'hd0000001,0);
        step(0,0,0,0, 1,32'hd0000002,0);
        step(1,0,0,0, 0,0,0);
        n_writes = 0;
        step(0,0,0,0, 0,0,1);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_ack", 32'(bus.wr_ack), 32'd0);
        for (int i = 0; i < 4; i++) step(0,0,0,0, 0,0,1);
        cmp("rst_no_write", 32'(n_writes), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0,299) == 0, $urandom_range(0,3) == 0, int'($urandom_range(0,127)),
                 int'($urandom_range(0,12)), 1'($urandom_range(0,1)), $urandom,
                 $urandom_range(0,9) < 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
